// File: rtl/fifo_reader_pkg.sv
// Shared types and default sizing for the fifo_reader read engine.
package fifo_reader_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DRAIN  = 2'd2
   } state_e;

   localparam int DEFAULT_FIFO_WIDTH = 16;
   localparam int DEFAULT_BUF_DEPTH  = 2;
   localparam int CNT_W              = 16;

endpackage

// File: rtl/fifo_reader_skid_buf.sv
// Small circular landing buffer between the FIFO read port and the
// downstream valid/ready stream.
module fifo_reader_skid_buf
   import fifo_reader_pkg::*;
#(
   parameter int FIFO_WIDTH = DEFAULT_FIFO_WIDTH,
   parameter int BUF_DEPTH  = DEFAULT_BUF_DEPTH
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               push,
   input  logic [FIFO_WIDTH-1:0]              push_data,
   input  logic                               pop,
   output logic                               m_valid,
   output logic [FIFO_WIDTH-1:0]              m_data,
   output logic [$clog2(BUF_DEPTH+1)-1:0]     occ
);

   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int OCC_W = $clog2(BUF_DEPTH+1);

   logic [FIFO_WIDTH-1:0] mem_q [BUF_DEPTH];
   logic [FIFO_WIDTH-1:0] mem_d [BUF_DEPTH];
   logic [PTR_W-1:0]      head_q, head_d;
   logic [PTR_W-1:0]      tail_q, tail_d;
   logic [OCC_W-1:0]      occ_q, occ_d;

   always_comb begin
      mem_d  = mem_q;
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;
      if (push) begin
         mem_d[tail_q] = push_data;
         tail_d = (tail_q == PTR_W'(BUF_DEPTH-1)) ? '0 : tail_q + PTR_W'(1);
      end
      if (pop) begin
         head_d = (head_q == PTR_W'(BUF_DEPTH-1)) ? '0 : head_q + PTR_W'(1);
      end
      unique case ({push, pop})
         2'b10:   occ_d = occ_q + OCC_W'(1);
         2'b01:   occ_d = occ_q - OCC_W'(1);
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: storage is reset too, so m_data reads 0 after reset instead of X.
         for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
      end else begin
         mem_q  <= mem_d;
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
      end
   end

   assign m_valid = (occ_q != '0);
   assign m_data  = mem_q[head_q];
   assign occ     = occ_q;

endmodule

// File: rtl/fifo_reader.sv
// Read-side engine for the synchronous FIFO: issue/drain FSM feeding a skid buffer.
// Optional FIFO_READER_STATS_EN adds word_cnt / stall_cnt outputs.
module fifo_reader
   import fifo_reader_pkg::*;
#(
   parameter int FIFO_WIDTH = DEFAULT_FIFO_WIDTH,
   parameter int BUF_DEPTH  = DEFAULT_BUF_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   output logic                  fifo_rd_en,
   input  logic [FIFO_WIDTH-1:0] fifo_data_out,
   input  logic                  fifo_empty,
   input  logic                  fifo_underflow,
   output logic                  m_valid,
   output logic [FIFO_WIDTH-1:0] m_data,
   input  logic                  m_ready,
`ifdef FIFO_READER_STATS_EN
   output logic [CNT_W-1:0]      word_cnt,
   output logic [CNT_W-1:0]      stall_cnt,
`endif
   output logic                  idle,
   output logic                  err_underflow
);

   localparam int OCC_W = $clog2(BUF_DEPTH+1);

   state_e           state_q, state_d;
   logic             rd_pend_q, rd_pend_d;
   logic             err_q, err_d;
   logic [OCC_W-1:0] occ;
   logic [OCC_W:0]   slots_used;
   logic             push, pop;

   assign pop  = m_valid && m_ready;
   assign push = rd_pend_q && !fifo_underflow;

   // Space still claimed after this cycle: buffered + in flight - leaving now.
   assign slots_used = ({1'b0, occ} + (OCC_W+1)'(rd_pend_q)) - (OCC_W+1)'(pop);

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      fifo_rd_en = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (en) state_d = ACTIVE;
         end
         ACTIVE: begin
            fifo_rd_en = !fifo_empty && (slots_used < (OCC_W+1)'(BUF_DEPTH));
            if (!en) state_d = DRAIN;
         end
         DRAIN: begin
            if (!rd_pend_q && ((occ == '0) || ((occ == OCC_W'(1)) && pop)))
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      rd_pend_d = fifo_rd_en;
      err_d     = err_q || (rd_pend_q && fifo_underflow);
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         rd_pend_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_pend_q <= rd_pend_d;
         err_q     <= err_d;
      end
   end

   assign idle          = (state_q == IDLE);
   assign err_underflow = err_q;

   fifo_reader_skid_buf #(
      .FIFO_WIDTH (FIFO_WIDTH),
      .BUF_DEPTH  (BUF_DEPTH)
   ) u_skid_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (fifo_data_out),
      .pop       (pop),
      .m_valid   (m_valid),
      .m_data    (m_data),
      .occ       (occ)
   );

`ifdef FIFO_READER_STATS_EN
   logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      word_cnt_d  = word_cnt_q + CNT_W'(pop);
      stall_cnt_d = stall_cnt_q;
      if (m_valid && !m_ready && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         word_cnt_q  <= word_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign word_cnt  = word_cnt_q;
   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader: vector table plus FIFO-model sequences.
module tb_fifo_reader;
   import fifo_reader_pkg::*;

   localparam int W = 16;

   logic         clk;
   logic         rst_n;
   logic         en;
   logic         fifo_rd_en;
   logic [W-1:0] fifo_data_out;
   logic         fifo_empty;
   logic         fifo_underflow;
   logic         m_valid;
   logic [W-1:0] m_data;
   logic         m_ready;
   logic         idle;
   logic         err_underflow;
`ifdef FIFO_READER_STATS_EN
   logic [CNT_W-1:0] word_cnt;
   logic [CNT_W-1:0] stall_cnt;
`endif

   fifo_reader #(.FIFO_WIDTH(W), .BUF_DEPTH(2)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .en             (en),
      .fifo_rd_en     (fifo_rd_en),
      .fifo_data_out  (fifo_data_out),
      .fifo_empty     (fifo_empty),
      .fifo_underflow (fifo_underflow),
      .m_valid        (m_valid),
      .m_data         (m_data),
      .m_ready        (m_ready),
`ifdef FIFO_READER_STATS_EN
      .word_cnt       (word_cnt),
      .stall_cnt      (stall_cnt),
`endif
      .idle           (idle),
      .err_underflow  (err_underflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic         en;
      logic         empty;
      logic         uf;
      logic         m_ready;
      logic [W-1:0] data;
      logic         exp_rd;
      logic         exp_mv;
      logic [W-1:0] exp_md;
      logic         exp_idle;
      logic         exp_err;
   } vec_t;

   localparam int NVEC = 18;
   vec_t vecs [NVEC];

   int       n_checks = 0;
   int       n_errors = 0;
   logic     use_model;
   logic [W-1:0] fq [$];

   function automatic vec_t mk(logic e, logic emp, logic uf, logic rdy, logic [W-1:0] d,
                               logic xrd, logic xmv, logic [W-1:0] xmd, logic xidle, logic xerr);
      vec_t v;
      v.en = e; v.empty = emp; v.uf = uf; v.m_ready = rdy; v.data = d;
      v.exp_rd = xrd; v.exp_mv = xmv; v.exp_md = xmd; v.exp_idle = xidle; v.exp_err = xerr;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One clock: the FIFO model answers a read sampled at this edge with 1-cycle latency.
   task automatic tick();
      logic rd;
      rd = fifo_rd_en;
      @(posedge clk);
      #1;
      if (use_model) begin
         if (rd) begin
            if (fq.size() > 0) begin
               fifo_data_out  = fq.pop_front();
               fifo_underflow = 1'b0;
            end else begin
               fifo_underflow = 1'b1;
            end
         end else begin
            fifo_underflow = 1'b0;
         end
         fifo_empty = (fq.size() == 0);
      end
      @(negedge clk);
   endtask

   task automatic do_reset(input logic model);
      rst_n          = 1'b0;
      en             = 1'b0;
      m_ready        = 1'b0;
      fifo_empty     = 1'b1;
      fifo_underflow = 1'b0;
      fifo_data_out  = '0;
      use_model      = model;
      fq.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic load_words(input int n);
      for (int i = 1; i <= n; i++) fq.push_back(W'(i));
      fifo_empty = (fq.size() == 0);
   endtask

   initial begin
      int first_rd, last_rd, first_mv, rd_cnt, seen_rd, seen_mv, seen_err;
      logic [W-1:0] got [$];

      // en, empty, uf, rdy, data | rd, mv, md, idle, err
      vecs[0]  = mk(0, 1, 0, 1, 16'h0000,  0, 0, 16'h0000, 1, 0);
      vecs[1]  = mk(1, 1, 0, 1, 16'h0000,  0, 0, 16'h0000, 1, 0);
      vecs[2]  = mk(1, 1, 0, 1, 16'h0000,  0, 0, 16'h0000, 0, 0);
      vecs[3]  = mk(1, 0, 0, 0, 16'h0000,  1, 0, 16'h0000, 0, 0);
      vecs[4]  = mk(1, 1, 0, 0, 16'hA5A5,  0, 0, 16'h0000, 0, 0);
      vecs[5]  = mk(1, 0, 0, 0, 16'h0000,  1, 1, 16'hA5A5, 0, 0);
      vecs[6]  = mk(1, 0, 0, 0, 16'h5A5A,  0, 1, 16'hA5A5, 0, 0);
      vecs[7]  = mk(1, 0, 0, 1, 16'h0000,  1, 1, 16'hA5A5, 0, 0);
      vecs[8]  = mk(1, 1, 0, 1, 16'h1234,  0, 1, 16'h5A5A, 0, 0);
      vecs[9]  = mk(0, 1, 0, 0, 16'h0000,  0, 1, 16'h1234, 0, 0);
      vecs[10] = mk(1, 0, 0, 0, 16'h0000,  0, 1, 16'h1234, 0, 0);
      vecs[11] = mk(1, 0, 0, 1, 16'h0000,  0, 1, 16'h1234, 0, 0);
      vecs[12] = mk(0, 0, 0, 1, 16'h0000,  0, 0, 16'h0000, 1, 0);
      vecs[13] = mk(1, 0, 0, 1, 16'h0000,  0, 0, 16'h0000, 1, 0);
      vecs[14] = mk(1, 0, 0, 1, 16'h0000,  1, 0, 16'h0000, 0, 0);
      vecs[15] = mk(1, 1, 1, 1, 16'hDEAD,  0, 0, 16'h0000, 0, 0);
      vecs[16] = mk(1, 1, 0, 1, 16'h0000,  0, 0, 16'h0000, 0, 1);
      vecs[17] = mk(1, 1, 0, 1, 16'h0000,  0, 0, 16'h0000, 0, 1);

      rst_n = 1'b0;
      #1;
      check("reset_idle", idle, 1);
      check("reset_m_valid", m_valid, 0);
      check("reset_m_data", m_data, 0);
      check("reset_rd_en", fifo_rd_en, 0);
      check("reset_err", err_underflow, 0);

      // ---------------- table-driven vectors ----------------
      do_reset(1'b0);
      for (int i = 0; i < NVEC; i++) begin
         en = vecs[i].en; fifo_empty = vecs[i].empty; fifo_underflow = vecs[i].uf;
         m_ready = vecs[i].m_ready; fifo_data_out = vecs[i].data;
         #1;
         check($sformatf("vec%0d_rd_en", i), fifo_rd_en, vecs[i].exp_rd);
         check($sformatf("vec%0d_m_valid", i), m_valid, vecs[i].exp_mv);
         if (vecs[i].exp_mv) check($sformatf("vec%0d_m_data", i), m_data, vecs[i].exp_md);
         check($sformatf("vec%0d_idle", i), idle, vecs[i].exp_idle);
         check($sformatf("vec%0d_err", i), err_underflow, vecs[i].exp_err);
         tick();
      end

      // Sticky error survives en toggling and only clears on reset.
      en = 1'b0;
      repeat (3) tick();
      check("err_sticky", err_underflow, 1);
      rst_n = 1'b0;
      #1;
      check("err_cleared_by_reset", err_underflow, 0);

      // ---------------- streaming throughput ----------------
      do_reset(1'b1);
      load_words(8);
      en = 1'b1; m_ready = 1'b1;
      first_rd = -1; last_rd = -1; first_mv = -1; rd_cnt = 0; got.delete();
      for (int c = 0; c < 30; c++) begin
         #1;
         if (fifo_rd_en) begin
            if (first_rd < 0) first_rd = c;
            last_rd = c;
            rd_cnt++;
         end
         if (m_valid && m_ready) begin
            if (first_mv < 0) first_mv = c;
            got.push_back(m_data);
         end
         tick();
      end
      check("stream_rd_count", rd_cnt, 8);
      check("stream_rd_consecutive", last_rd - first_rd, 7);
      check("stream_first_valid_lat", first_mv - first_rd, 2);
      check("stream_word_count", got.size(), 8);
      for (int i = 0; i < got.size() && i < 8; i++)
         check($sformatf("stream_word%0d", i), got[i], i + 1);

      // ---------------- backpressure ----------------
      do_reset(1'b1);
      load_words(8);
      en = 1'b1; m_ready = 1'b0;
      rd_cnt = 0;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (fifo_rd_en) rd_cnt++;
         tick();
      end
      #1;
      check("bp_reads_issued", rd_cnt, 2);
      check("bp_rd_en_low", fifo_rd_en, 0);
      check("bp_m_valid", m_valid, 1);
      check("bp_m_data_held", m_data, 1);
      m_ready = 1'b1;
      got.delete();
      for (int c = 0; c < 20; c++) begin
         #1;
         if (fifo_rd_en) rd_cnt++;
         if (m_valid && m_ready) got.push_back(m_data);
         tick();
      end
      check("bp_total_reads", rd_cnt, 8);
      check("bp_total_words", got.size(), 8);
      for (int i = 0; i < got.size() && i < 8; i++)
         check($sformatf("bp_word%0d", i), got[i], i + 1);
      check("bp_empty_after", m_valid, 0);

      // ---------------- empty FIFO with en held ----------------
      do_reset(1'b1);
      en = 1'b1; m_ready = 1'b1;
      seen_rd = 0; seen_mv = 0; seen_err = 0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (fifo_rd_en) seen_rd++;
         if (m_valid) seen_mv++;
         if (err_underflow) seen_err++;
         tick();
      end
      check("empty_no_rd", seen_rd, 0);
      check("empty_no_valid", seen_mv, 0);
      check("empty_no_err", seen_err, 0);

      // ---------------- drain with a read in flight ----------------
      do_reset(1'b1);
      load_words(2);
      en = 1'b1; m_ready = 1'b1;
      #1; check("drain_c0_idle", idle, 1); tick();
      #1; check("drain_c1_rd", fifo_rd_en, 1); tick();
      #1; check("drain_c2_rd", fifo_rd_en, 1); tick();
      en = 1'b0;
      #1;
      check("drain_c3_rd", fifo_rd_en, 0);
      check("drain_c3_m_valid", m_valid, 1);
      check("drain_c3_m_data", m_data, 1);
      tick();
      #1;
      check("drain_c4_rd", fifo_rd_en, 0);
      check("drain_c4_m_data", m_data, 2);
      check("drain_c4_idle", idle, 0);
      tick();
      #1;
      check("drain_c5_idle", idle, 1);
      check("drain_c5_m_valid", m_valid, 0);

      // ---------------- reset mid-stream ----------------
      do_reset(1'b1);
      load_words(8);
      en = 1'b1; m_ready = 1'b0;
      repeat (5) tick();
      #1;
      check("midrst_pre_valid", m_valid, 1);
      rst_n = 1'b0;
      #1;
      check("midrst_m_valid", m_valid, 0);
      check("midrst_rd_en", fifo_rd_en, 0);
      check("midrst_idle", idle, 1);
      check("midrst_err", err_underflow, 0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
